// File: rtl/fb_pixel_packer.sv
// ---------------------------------------------------------------------------
// fb_pixel_packer
//
// Packs single 12-bit pixels from a rasterizer into 48-bit words of a
// masked dual-port framebuffer BRAM.  Pixels that land in the same word
// are merged into a pending-word register and written once, with a
// per-lane write mask.  The pending word is written when a pixel for a
// different word arrives or when flush is asserted.  A clear request
// fills the whole buffer with one colour, one word per cycle.
//
// Ports
//   clk        single clock, rising edge
//   rst        synchronous active-high reset
//   px_valid   pixel request
//   px_ready   pixel accepted when px_valid && px_ready
//   px_idx     linear pixel index: word = idx[AW+1:2], lane = idx[1:0]
//   px_color   pixel colour
//   flush      write out the pending word
//   clr_start  start a full-buffer clear (priority over px_valid/flush)
//   clr_color  clear colour, sampled with clr_start
//   clr_done   one-cycle pulse alongside the last clear write
//   busy       clearing, or a pending word is held
//   err_oob    sticky: an out-of-range pixel was dropped
//   mem_cen    BRAM chip enable, active-low
//   mem_gwen   BRAM global write enable, 1 = write (never reads)
//   mem_wen    per-lane write mask, active-low
//   mem_addr   BRAM word address
//   mem_din    BRAM write data
// ---------------------------------------------------------------------------
module fb_pixel_packer #(
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = 48,
    parameter int DEPTH_WORDS = 640
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  px_valid,
    output logic                  px_ready,
    input  logic [ADDR_WIDTH+1:0] px_idx,
    input  logic [11:0]           px_color,
    input  logic                  flush,
    input  logic                  clr_start,
    input  logic [11:0]           clr_color,
    output logic                  clr_done,
    output logic                  busy,
    output logic                  err_oob,
    output logic                  mem_cen,
    output logic                  mem_gwen,
    output logic [3:0]            mem_wen,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din
);

    localparam int LANE_W = DATA_WIDTH / 4;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH_WORDS);
    localparam logic [ADDR_WIDTH:0] LAST_C  = (ADDR_WIDTH+1)'(DEPTH_WORDS - 1);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_stateNext;

    logic                  r_pendValid;
    logic [ADDR_WIDTH-1:0] r_pendAddr;
    logic [DATA_WIDTH-1:0] r_pendData;
    logic [3:0]            r_pendMask;

    logic [11:0]           r_clrColor;
    logic [ADDR_WIDTH:0]   r_clrCnt;

    logic                  r_memCen;
    logic [3:0]            r_memWen;
    logic [ADDR_WIDTH-1:0] r_memAddr;
    logic [DATA_WIDTH-1:0] r_memDin;
    logic                  r_clrDone;
    logic                  r_errOob;

    logic [ADDR_WIDTH-1:0] w_pxWord;
    logic [1:0]            w_pxLane;
    logic [3:0]            w_laneBit;
    logic [5:0]            w_laneBase;
    logic                  w_pxInRange;
    logic                  w_sameWord;

    assign w_pxWord    = px_idx[ADDR_WIDTH+1:2];
    assign w_pxLane    = px_idx[1:0];
    assign w_laneBit   = 4'b0001 << w_pxLane;
    assign w_laneBase  = 6'(w_pxLane) * 6'(LANE_W);
    assign w_pxInRange = {1'b0, w_pxWord} < DEPTH_C;
    assign w_sameWord  = r_pendValid && (r_pendAddr == w_pxWord);

    assign px_ready = (r_state == ST_RUN) && !flush && !clr_start;
    assign busy     = (r_state == ST_CLEAR) || r_pendValid;
    assign clr_done = r_clrDone;
    assign err_oob  = r_errOob;
    assign mem_cen  = r_memCen;
    assign mem_gwen = 1'b1;
    assign mem_wen  = r_memWen;
    assign mem_addr = r_memAddr;
    assign mem_din  = r_memDin;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next state.  CLEAR is left one cycle after the last clear write has
    // been registered, so px_ready stays low while that write is on the bus.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            ST_RUN: begin
                if (clr_start) begin
                    w_stateNext = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (r_clrCnt == DEPTH_C) begin
                    w_stateNext = ST_RUN;
                end
            end
            default: w_stateNext = ST_RUN;
        endcase
    end

    // Pending-word datapath and registered BRAM port.  Every write is
    // registered here, so it appears on mem_* the cycle after the edge that
    // triggered it and lasts exactly one cycle.  When a pixel for a new word
    // displaces the pending one, the old contents are written while the new
    // pixel is loaded on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pendValid <= 1'b0;
            r_pendAddr  <= '0;
            r_pendData  <= '0;
            r_pendMask  <= 4'h0;
            r_clrColor  <= 12'h000;
            r_clrCnt    <= '0;
            r_memCen    <= 1'b1;
            r_memWen    <= 4'hF;
            r_memAddr   <= '0;
            r_memDin    <= '0;
            r_clrDone   <= 1'b0;
            r_errOob    <= 1'b0;
        end else begin
            r_memCen  <= 1'b1;
            r_memWen  <= 4'hF;
            r_clrDone <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    if (clr_start) begin
                        r_pendValid <= 1'b0;
                        r_clrColor  <= clr_color;
                        r_clrCnt    <= '0;
                    end else if (flush) begin
                        if (r_pendValid) begin
                            r_memCen    <= 1'b0;
                            r_memWen    <= ~r_pendMask;
                            r_memAddr   <= r_pendAddr;
                            r_memDin    <= r_pendData;
                            r_pendValid <= 1'b0;
                        end
                    end else if (px_valid) begin
                        if (!w_pxInRange) begin
                            r_errOob <= 1'b1;
                        end else begin
                            if (r_pendValid && !w_sameWord) begin
                                r_memCen  <= 1'b0;
                                r_memWen  <= ~r_pendMask;
                                r_memAddr <= r_pendAddr;
                                r_memDin  <= r_pendData;
                            end
                            if (w_sameWord) begin
                                r_pendMask <= r_pendMask | w_laneBit;
                            end else begin
                                r_pendMask <= w_laneBit;
                            end
                            r_pendValid <= 1'b1;
                            r_pendAddr  <= w_pxWord;
                            r_pendData[w_laneBase +: LANE_W] <= px_color;
                        end
                    end
                end
                ST_CLEAR: begin
                    if (r_clrCnt != DEPTH_C) begin
                        r_memCen  <= 1'b0;
                        r_memWen  <= 4'h0;
                        r_memAddr <= r_clrCnt[ADDR_WIDTH-1:0];
                        r_memDin  <= {4{r_clrColor}};
                        r_clrDone <= (r_clrCnt == LAST_C);
                        r_clrCnt  <= r_clrCnt + 1'b1;
                    end
                end
                default: begin
                    r_pendValid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fb_pixel_packer.sv
// ---------------------------------------------------------------------------
// tb_fb_pixel_packer
//
// Self-checking bench for fb_pixel_packer.  Directed scenarios cover the
// basic packing cases, out-of-range drops, the buffer clear and a reset
// in the middle of a clear.  A randomized run compares the DUT against a
// model that tracks the pending word as a set of lanes with colours.
// ---------------------------------------------------------------------------
module tb_fb_pixel_packer;

    localparam int AW    = 10;
    localparam int DW    = 48;
    localparam int DEPTH = 640;
    localparam int IW    = AW + 2;

    logic          clk;
    logic          rst;
    logic          px_valid;
    logic          px_ready;
    logic [IW-1:0] px_idx;
    logic [11:0]   px_color;
    logic          flush;
    logic          clr_start;
    logic [11:0]   clr_color;
    logic          clr_done;
    logic          busy;
    logic          err_oob;
    logic          mem_cen;
    logic          mem_gwen;
    logic [3:0]    mem_wen;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;

    int total = 0;
    int bad   = 0;

    fb_pixel_packer #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .DEPTH_WORDS(DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .px_valid (px_valid),
        .px_ready (px_ready),
        .px_idx   (px_idx),
        .px_color (px_color),
        .flush    (flush),
        .clr_start(clr_start),
        .clr_color(clr_color),
        .clr_done (clr_done),
        .busy     (busy),
        .err_oob  (err_oob),
        .mem_cen  (mem_cen),
        .mem_gwen (mem_gwen),
        .mem_wen  (mem_wen),
        .mem_addr (mem_addr),
        .mem_din  (mem_din)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Any enabled BRAM access must be a write.
    always @(negedge clk) begin
        if (mem_cen === 1'b0) begin
            total++;
            if (mem_gwen !== 1'b1) begin
                bad++;
                $display("[TB] FAIL no_read: mem_gwen=%b required 1", mem_gwen);
            end
        end
    end

    // Hang guard.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance one cycle: inputs set before the rising edge, outputs
    // observed at the following falling edge.
    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idleInputs;
        px_valid  = 1'b0;
        px_idx    = '0;
        px_color  = 12'h000;
        flush     = 1'b0;
        clr_start = 1'b0;
        clr_color = 12'h000;
    endtask

    task automatic pix(input int idx, input logic [11:0] col);
        px_valid  = 1'b1;
        px_idx    = IW'(idx);
        px_color  = col;
        flush     = 1'b0;
        clr_start = 1'b0;
        tick();
        px_valid  = 1'b0;
    endtask

    task automatic doFlush;
        px_valid = 1'b0;
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
    endtask

    task automatic test_reset;
        rst       = 1'b1;
        px_valid  = 1'b1;
        px_idx    = IW'(5);
        px_color  = 12'hFFF;
        tick();
        tick();
        rst      = 1'b0;
        px_valid = 1'b0;
        #1;
        total++;
        if (mem_cen !== 1'b1 || mem_gwen !== 1'b1 || mem_wen !== 4'hF) begin
            bad++;
            $display("[TB] FAIL reset_ctrl: cen=%b gwen=%b wen=%h required 1 1 F", mem_cen, mem_gwen, mem_wen);
        end
        total++;
        if (mem_addr !== '0 || mem_din !== '0) begin
            bad++;
            $display("[TB] FAIL reset_bus: addr=%0d din=%h required 0 0", mem_addr, mem_din);
        end
        total++;
        if (clr_done !== 1'b0 || err_oob !== 1'b0 || busy !== 1'b0 || px_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reset_flags: done=%b oob=%b busy=%b ready=%b required 0 0 0 1", clr_done, err_oob, busy, px_ready);
        end
    endtask

    task automatic test_full_word;
        pix(0, 12'h111);
        pix(1, 12'h222);
        pix(2, 12'h333);
        pix(3, 12'h444);
        total++;
        if (mem_cen !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL full_merge: cen=%b busy=%b required 1 1", mem_cen, busy);
        end
        doFlush();
        total++;
        if (mem_cen !== 1'b0 || mem_addr !== AW'(0) || mem_wen !== 4'h0 || mem_din !== 48'h444333222111) begin
            bad++;
            $display("[TB] FAIL full_write: cen=%b addr=%0d wen=%h din=%h required 0 0 0 444333222111", mem_cen, mem_addr, mem_wen, mem_din);
        end
        tick();
        total++;
        if (mem_cen !== 1'b1 || mem_wen !== 4'hF || mem_addr !== AW'(0) || busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL full_after: cen=%b wen=%h addr=%0d busy=%b required 1 F 0 0", mem_cen, mem_wen, mem_addr, busy);
        end
    endtask

    task automatic test_addr_change;
        pix(5, 12'hA5A);
        pix(9, 12'h0F0);
        total++;
        if (mem_cen !== 1'b0 || mem_addr !== AW'(1) || mem_wen !== 4'b1101 || mem_din[23:12] !== 12'hA5A) begin
            bad++;
            $display("[TB] FAIL addr_change_1: cen=%b addr=%0d wen=%b lane1=%h required 0 1 1101 A5A", mem_cen, mem_addr, mem_wen, mem_din[23:12]);
        end
        doFlush();
        total++;
        if (mem_cen !== 1'b0 || mem_addr !== AW'(2) || mem_wen !== 4'b1101 || mem_din[23:12] !== 12'h0F0) begin
            bad++;
            $display("[TB] FAIL addr_change_2: cen=%b addr=%0d wen=%b lane1=%h required 0 2 1101 0F0", mem_cen, mem_addr, mem_wen, mem_din[23:12]);
        end
    endtask

    task automatic test_same_lane;
        pix(2, 12'h123);
        pix(2, 12'h456);
        total++;
        if (mem_cen !== 1'b1) begin
            bad++;
            $display("[TB] FAIL same_lane_nowrite: cen=%b required 1", mem_cen);
        end
        doFlush();
        total++;
        if (mem_cen !== 1'b0 || mem_addr !== AW'(0) || mem_wen !== 4'b1011 || mem_din[35:24] !== 12'h456) begin
            bad++;
            $display("[TB] FAIL same_lane_write: cen=%b addr=%0d wen=%b lane2=%h required 0 0 1011 456", mem_cen, mem_addr, mem_wen, mem_din[35:24]);
        end
    endtask

    task automatic test_flush_noop;
        doFlush();
        total++;
        if (mem_cen !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL flush_noop: cen=%b busy=%b required 1 0", mem_cen, busy);
        end
    endtask

    task automatic test_back_to_back;
        pix(40, 12'h101);
        total++;
        if (mem_cen !== 1'b1) begin
            bad++;
            $display("[TB] FAIL b2b_first: cen=%b required 1", mem_cen);
        end
        pix(45, 12'h202);
        total++;
        if (mem_cen !== 1'b0 || mem_addr !== AW'(10) || mem_wen !== 4'b1110 || mem_din[11:0] !== 12'h101) begin
            bad++;
            $display("[TB] FAIL b2b_w10: cen=%b addr=%0d wen=%b lane0=%h required 0 10 1110 101", mem_cen, mem_addr, mem_wen, mem_din[11:0]);
        end
        pix(50, 12'h303);
        total++;
        if (mem_cen !== 1'b0 || mem_addr !== AW'(11) || mem_wen !== 4'b1101 || mem_din[23:12] !== 12'h202) begin
            bad++;
            $display("[TB] FAIL b2b_w11: cen=%b addr=%0d wen=%b lane1=%h required 0 11 1101 202", mem_cen, mem_addr, mem_wen, mem_din[23:12]);
        end
        doFlush();
        total++;
        if (mem_cen !== 1'b0 || mem_addr !== AW'(12) || mem_wen !== 4'b1011 || mem_din[35:24] !== 12'h303) begin
            bad++;
            $display("[TB] FAIL b2b_w12: cen=%b addr=%0d wen=%b lane2=%h required 0 12 1011 303", mem_cen, mem_addr, mem_wen, mem_din[35:24]);
        end
    endtask

    task automatic test_oob;
        pix(6, 12'h777);
        pix(4 * DEPTH, 12'h999);
        total++;
        if (mem_cen !== 1'b1 || err_oob !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL oob_drop: cen=%b oob=%b busy=%b required 1 1 1", mem_cen, err_oob, busy);
        end
        doFlush();
        total++;
        if (mem_cen !== 1'b0 || mem_addr !== AW'(1) || mem_wen !== 4'b1011 || mem_din[35:24] !== 12'h777) begin
            bad++;
            $display("[TB] FAIL oob_pending: cen=%b addr=%0d wen=%b lane2=%h required 0 1 1011 777", mem_cen, mem_addr, mem_wen, mem_din[35:24]);
        end
        tick();
        tick();
        total++;
        if (err_oob !== 1'b1) begin
            bad++;
            $display("[TB] FAIL oob_sticky: oob=%b required 1", err_oob);
        end
    endtask

    // Model: the pending word is a word address plus, per lane, whether a
    // colour has been collected and which colour is newest.
    task automatic test_random;
        bit          mHas;
        int          mAddr;
        bit          mLv[4];
        logic [11:0] mLc[4];
        bit          mErr;
        int          lastAddr;
        bit          expWr;
        int          expAddr;
        bit          expLv[4];
        logic [11:0] expLc[4];
        logic [3:0]  expWen;
        int          op;
        int          wsel;
        int          word;
        int          lane;
        logic [11:0] col;

        idleInputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mHas     = 1'b0;
        mAddr    = 0;
        mErr     = 1'b0;
        lastAddr = 0;
        expAddr  = 0;
        for (int l = 0; l < 4; l++) begin
            mLv[l] = 1'b0;
            mLc[l] = 12'h000;
            expLv[l] = 1'b0;
            expLc[l] = 12'h000;
        end

        for (int n = 0; n < 400; n++) begin
            op    = int'($urandom_range(0, 9));
            expWr = 1'b0;
            px_valid = 1'b0;
            flush    = 1'b0;
            if (op < 2) begin
                flush = 1'b1;
                if (mHas) begin
                    expWr = 1'b1; expAddr = mAddr; expLv = mLv; expLc = mLc;
                    mHas  = 1'b0;
                end
            end else if (op >= 3) begin
                wsel = int'($urandom_range(0, 5));
                case (wsel)
                    0, 1, 2: word = wsel;
                    3:       word = DEPTH - 2;
                    4:       word = DEPTH - 1;
                    default: word = int'($urandom_range(DEPTH, 1023));
                endcase
                lane = int'($urandom_range(0, 3));
                col  = 12'($urandom);
                px_valid = 1'b1;
                px_idx   = IW'(word * 4 + lane);
                px_color = col;
                if (word >= DEPTH) begin
                    mErr = 1'b1;
                end else begin
                    if (mHas && mAddr != word) begin
                        expWr = 1'b1; expAddr = mAddr; expLv = mLv; expLc = mLc;
                        mHas  = 1'b0;
                    end
                    if (!mHas) begin
                        mHas  = 1'b1;
                        mAddr = word;
                        for (int l = 0; l < 4; l++) mLv[l] = 1'b0;
                    end
                    mLv[lane] = 1'b1;
                    mLc[lane] = col;
                end
            end
            #1;
            total++;
            if (px_ready !== (flush ? 1'b0 : 1'b1)) begin
                bad++;
                $display("[TB] FAIL rnd_ready[%0d]: ready=%b flush=%b", n, px_ready, flush);
            end
            tick();
            total++;
            if (mem_cen !== (expWr ? 1'b0 : 1'b1)) begin
                bad++;
                $display("[TB] FAIL rnd_cen[%0d]: cen=%b required %b", n, mem_cen, !expWr);
            end
            if (expWr) begin
                for (int l = 0; l < 4; l++) expWen[l] = !expLv[l];
                total++;
                if (mem_addr !== AW'(expAddr) || mem_wen !== expWen) begin
                    bad++;
                    $display("[TB] FAIL rnd_write[%0d]: addr=%0d wen=%b required %0d %b", n, mem_addr, mem_wen, expAddr, expWen);
                end
                for (int l = 0; l < 4; l++) begin
                    if (expLv[l]) begin
                        total++;
                        if (mem_din[l*12 +: 12] !== expLc[l]) begin
                            bad++;
                            $display("[TB] FAIL rnd_lane[%0d] lane %0d: got %h required %h", n, l, mem_din[l*12 +: 12], expLc[l]);
                        end
                    end
                end
                lastAddr = expAddr;
            end else begin
                total++;
                if (mem_addr !== AW'(lastAddr) || mem_wen !== 4'hF) begin
                    bad++;
                    $display("[TB] FAIL rnd_hold[%0d]: addr=%0d wen=%b required %0d 1111", n, mem_addr, mem_wen, lastAddr);
                end
            end
            total++;
            if (busy !== mHas || err_oob !== mErr) begin
                bad++;
                $display("[TB] FAIL rnd_flags[%0d]: busy=%b oob=%b required %b %b", n, busy, err_oob, mHas, mErr);
            end
        end
        idleInputs();
        doFlush();
    endtask

    task automatic test_clear;
        int expAddr;
        int cycles;

        pix(7, 12'h321);
        clr_start = 1'b1;
        clr_color = 12'hABC;
        px_valid  = 1'b1;
        px_idx    = IW'(20);
        px_color  = 12'hFFF;
        flush     = 1'b1;
        #1;
        total++;
        if (px_ready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL clr_prio_ready: ready=%b required 0", px_ready);
        end
        tick();
        flush     = 1'b0;
        px_idx    = IW'(24);
        px_color  = 12'h777;
        expAddr   = 0;
        cycles    = 0;
        while (expAddr < DEPTH && cycles < DEPTH + 20) begin
            if (cycles == 300) begin
                clr_start = 1'b1;
                clr_color = 12'h555;
            end else begin
                clr_start = 1'b0;
                clr_color = 12'h000;
            end
            #1;
            total++;
            if (px_ready !== 1'b0) begin
                bad++;
                $display("[TB] FAIL clr_ready at %0d: ready=%b required 0", expAddr, px_ready);
            end
            if (mem_cen === 1'b0) begin
                total++;
                if (mem_addr !== AW'(expAddr) || mem_wen !== 4'h0 || mem_din !== {4{12'hABC}} ||
                    clr_done !== ((expAddr == DEPTH - 1) ? 1'b1 : 1'b0)) begin
                    bad++;
                    $display("[TB] FAIL clr_write: addr=%0d wen=%h din=%h done=%b required %0d 0 ABCABCABCABC %b",
                             mem_addr, mem_wen, mem_din, clr_done, expAddr, (expAddr == DEPTH - 1));
                end
                expAddr++;
            end else begin
                total++;
                if (expAddr != 0 || clr_done !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL clr_gap: idle cycle after %0d writes, done=%b", expAddr, clr_done);
                end
            end
            cycles++;
            tick();
        end
        clr_start = 1'b0;
        total++;
        if (expAddr != DEPTH) begin
            bad++;
            $display("[TB] FAIL clr_count: writes=%0d required %0d", expAddr, DEPTH);
        end
        px_valid = 1'b0;
        cycles   = 0;
        #1;
        while (px_ready !== 1'b1 && cycles < 4) begin
            tick();
            #1;
            cycles++;
        end
        total++;
        if (px_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL clr_exit: ready=%b required 1", px_ready);
        end
        total++;
        if (busy !== 1'b0 || clr_done !== 1'b0 || mem_cen !== 1'b1) begin
            bad++;
            $display("[TB] FAIL clr_after: busy=%b done=%b cen=%b required 0 0 1", busy, clr_done, mem_cen);
        end
    endtask

    task automatic test_clear_reset;
        int cycles;

        idleInputs();
        pix(13, 12'h246);
        clr_start = 1'b1;
        clr_color = 12'h0F0;
        tick();
        clr_start = 1'b0;
        cycles = 0;
        while (!(mem_cen === 1'b0 && mem_addr === AW'(100)) && cycles < 200) begin
            tick();
            cycles++;
        end
        total++;
        if (mem_cen !== 1'b0 || mem_addr !== AW'(100)) begin
            bad++;
            $display("[TB] FAIL clrrst_reach: cen=%b addr=%0d required 0 100", mem_cen, mem_addr);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        for (int c = 0; c < 20; c++) begin
            total++;
            if (mem_cen !== 1'b1 || clr_done !== 1'b0 || px_ready !== 1'b1 || busy !== 1'b0 || err_oob !== 1'b0) begin
                bad++;
                $display("[TB] FAIL clrrst_quiet[%0d]: cen=%b done=%b ready=%b busy=%b oob=%b required 1 0 1 0 0",
                         c, mem_cen, clr_done, px_ready, busy, err_oob);
            end
            tick();
            #1;
        end
    endtask

    initial begin
        rst = 1'b1;
        idleInputs();
        @(negedge clk);
        test_reset();
        test_full_word();
        test_addr_change();
        test_same_lane();
        test_flush_noop();
        test_back_to_back();
        test_oob();
        test_random();
        test_clear();
        test_clear_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
